// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Register file with one write port and two independent registered read
//   ports. Each entry carries a valid flag that is set by a write and cleared
//   by reset or by the synchronous clear. Reads have a latency of one cycle.
//
//   Optional feature (compile-time macro):
//     REGFILE_BYPASS_EN  - a read that hits the entry being written on the
//                          same edge returns the new data (write-first).
//                          Without it, the read returns the previous
//                          contents (read-first).
//
// Parameters
//   WIDTH  bits per entry and per data port
//   DEPTH  number of entries (2..256)
//   AW     address width, 2**AW >= DEPTH
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   wr          write enable
//   wr_addr     write address
//   data_in     write data
//   clr         synchronous clear of all entries, flags and read outputs
//   rd_addr_a   read address, port A
//   rd_addr_b   read address, port B
//   data_out_a  registered read data, port A
//   data_out_b  registered read data, port B
//   valid_a     addressed entry written since last reset/clear, port A
//   valid_b     addressed entry written since last reset/clear, port B
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_a,
  output logic             valid_b
);

  // One extra bit so DEPTH = 2**AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic             wr_in_range;
  logic             rd_a_in_range;
  logic             rd_b_in_range;
  logic             wr_hit;

  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid_a;
  logic             rd_valid_b;

  assign wr_in_range   = ({1'b0, wr_addr}   < DEPTH_W);
  assign rd_a_in_range = ({1'b0, rd_addr_a} < DEPTH_W);
  assign rd_b_in_range = ({1'b0, rd_addr_b} < DEPTH_W);

  // A write only lands when enabled, in range and not overridden by clr.
  assign wr_hit = wr && !clr && wr_in_range;

  // Next values for the read registers. Out-of-range addresses read as an
  // empty entry rather than indexing past the array.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    rd_data_a  = '0;
    rd_valid_a = 1'b0;
    rd_data_b  = '0;
    rd_valid_b = 1'b0;

    if (rd_a_in_range) begin
      rd_data_a  = mem[rd_addr_a];
      rd_valid_a = valid_q[rd_addr_a];
    end
    if (rd_b_in_range) begin
      rd_data_b  = mem[rd_addr_b];
      rd_valid_b = valid_q[rd_addr_b];
    end

`ifdef REGFILE_BYPASS_EN
    // Write-first: forward the incoming data to a port reading that entry.
    if (wr_hit && (rd_addr_a == wr_addr)) begin
      rd_data_a  = data_in;
      rd_valid_a = 1'b1;
    end
    if (wr_hit && (rd_addr_b == wr_addr)) begin
      rd_data_b  = data_in;
      rd_valid_b = 1'b1;
    end
`endif
  end

  // Storage, flags and read registers share one process so reset and clear
  // act on all of them at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage array is reset here on purpose: reads of never
      // written entries must return zero, and this forces a flop-based
      // array rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid_q    <= '0;
      data_out_a <= '0;
      data_out_b <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid_q    <= '0;
      data_out_a <= '0;
      data_out_b <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the read registers sample the
      // pre-edge array contents, which is what gives read-first behaviour
      // when bypass is not compiled in.
      if (wr_hit) begin
        mem[wr_addr]     <= data_in;
        valid_q[wr_addr] <= 1'b1;
      end
      data_out_a <= rd_data_a;
      data_out_b <= rd_data_b;
      valid_a    <= rd_valid_a;
      valid_b    <= rd_valid_b;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//   Directed self-checking bench for regfile_2r1w. Two instances share the
//   same stimulus: the default 8-entry build and a 6-entry build used for
//   out-of-range addressing. Expected values are hand-derived constants plus
//   a small array model for the random write sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] data_in = '0;
  logic       clr = 1'b0;
  logic [2:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;

  logic [7:0] data_out_a, data_out_b;
  logic       valid_a, valid_b;
  logic [7:0] d6_data_out_a, d6_data_out_b;
  logic       d6_valid_a, d6_valid_b;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .data_in(data_in),
    .clr(clr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .valid_a(valid_a), .valid_b(valid_b)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .AW(3)) dut6 (
    .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .data_in(data_in),
    .clr(clr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .data_out_a(d6_data_out_a), .data_out_b(d6_data_out_b),
    .valid_a(d6_valid_a), .valid_b(d6_valid_b)
  );

  // Advance past one rising edge; outputs are stable 1 ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({data_out_a, valid_a, data_out_b, valid_b} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got %h/%b %h/%b, want 00/0 00/0",
               data_out_a, valid_a, data_out_b, valid_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      cycle();
      n_cmp++;
      if ({data_out_a, valid_a, data_out_b, valid_b} !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_read_%0d: got %h/%b %h/%b, want 00/0 00/0",
                 i, data_out_a, valid_a, data_out_b, valid_b);
      end
    end
  endtask

  // Write presented while rst is high is dropped; the first write after
  // release lands normally.
  task automatic test_reset_mid();
    wr = 1'b1; wr_addr = 3'd1; data_in = 8'h5A;
    rd_addr_a = 3'd1; rd_addr_b = 3'd1;
    rst = 1'b1;
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a, data_out_b, valid_b} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h/%b %h/%b, want 00/0 00/0",
               data_out_a, valid_a, data_out_b, valid_b);
    end
    rst = 1'b0; wr = 1'b0;
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_write_dropped: got %h/%b, want 00/0", data_out_a, valid_a);
    end
    wr = 1'b1;
    cycle();
    wr = 1'b0;
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a} !== {8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_write: got %h/%b, want 5a/1", data_out_a, valid_a);
    end
  endtask

  task automatic test_write_read();
    wr = 1'b1; wr_addr = 3'd3; data_in = 8'hA5;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    cycle();
    wr = 1'b0;
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a, data_out_b, valid_b} !== {8'hA5, 1'b1, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL write_read: got %h/%b %h/%b, want a5/1 a5/1",
               data_out_a, valid_a, data_out_b, valid_b);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_first;
    exp_first = BYPASS ? 8'h22 : 8'h11;
    wr = 1'b1; wr_addr = 3'd5; data_in = 8'h11;
    cycle();
    data_in = 8'h22;
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    cycle();
    wr = 1'b0;
    n_cmp++;
    if ({data_out_a, valid_a, data_out_b, valid_b} !== {exp_first, 1'b1, exp_first, 1'b1}) begin
      n_fail++;
      $display("FAIL bypass_same_edge: got %h/%b %h/%b, want %h/1 %h/1",
               data_out_a, valid_a, data_out_b, valid_b, exp_first, exp_first);
    end
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a} !== {8'h22, 1'b1}) begin
      n_fail++;
      $display("FAIL bypass_next_edge: got %h/%b, want 22/1", data_out_a, valid_a);
    end
  endtask

  task automatic test_clear();
    wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_addr = 3'(i);
      data_in = 8'(8'h10 + i);
      cycle();
    end
    wr_addr = 3'd2; data_in = 8'h7E; clr = 1'b1;
    rd_addr_a = 3'd2; rd_addr_b = 3'd7;
    cycle();
    n_cmp++;
    if ({data_out_a, valid_a, data_out_b, valid_b} !== 18'h0) begin
      n_fail++;
      $display("FAIL clear_outputs: got %h/%b %h/%b, want 00/0 00/0",
               data_out_a, valid_a, data_out_b, valid_b);
    end
    clr = 1'b0; wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(i);
      cycle();
      n_cmp++;
      if ({data_out_a, valid_a, data_out_b, valid_b} !== 18'h0) begin
        n_fail++;
        $display("FAIL clear_entry_%0d: got %h/%b %h/%b, want 00/0 00/0",
                 i, data_out_a, valid_a, data_out_b, valid_b);
      end
    end
  endtask

  // Uses the 6-entry instance: addresses 6 and 7 are out of range.
  task automatic test_out_of_range();
    pulse_reset();
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 3'(i);
      data_in = 8'(8'hC0 + i);
      cycle();
    end
    wr_addr = 3'd6; data_in = 8'h33;
    cycle();
    wr = 1'b0;
    rd_addr_a = 3'd6; rd_addr_b = 3'd7;
    cycle();
    n_cmp++;
    if ({d6_data_out_a, d6_valid_a, d6_data_out_b, d6_valid_b} !== 18'h0) begin
      n_fail++;
      $display("FAIL oor_read: got %h/%b %h/%b, want 00/0 00/0",
               d6_data_out_a, d6_valid_a, d6_data_out_b, d6_valid_b);
    end
    for (int i = 0; i < 6; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(5 - i);
      cycle();
      n_cmp++;
      if ({d6_data_out_a, d6_valid_a, d6_data_out_b, d6_valid_b} !==
          {8'(8'hC0 + i), 1'b1, 8'(8'hC5 - i), 1'b1}) begin
        n_fail++;
        $display("FAIL oor_entry_%0d: got %h/%b %h/%b, want %h/1 %h/1",
                 i, d6_data_out_a, d6_valid_a, d6_data_out_b, d6_valid_b,
                 8'(8'hC0 + i), 8'(8'hC5 - i));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] m_data [8];
    logic       m_val  [8];
    logic [7:0] ea_d, eb_d;
    logic       ea_v, eb_v;
    logic [2:0] a, b;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      m_data[i] = '0;
      m_val[i]  = 1'b0;
    end
    pulse_reset();
    for (int n = 0; n < 10; n++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      wr = 1'b1; wr_addr = a; data_in = d;
      rd_addr_a = a; rd_addr_b = b;
      ea_d = BYPASS ? d : m_data[a];
      ea_v = BYPASS ? 1'b1 : m_val[a];
      eb_d = (BYPASS && b == a) ? d : m_data[b];
      eb_v = (BYPASS && b == a) ? 1'b1 : m_val[b];
      cycle();
      m_data[a] = d;
      m_val[a]  = 1'b1;
      n_cmp++;
      if ({data_out_a, valid_a, data_out_b, valid_b} !== {ea_d, ea_v, eb_d, eb_v}) begin
        n_fail++;
        $display("FAIL rand_wr_%0d: got %h/%b %h/%b, want %h/%b %h/%b",
                 n, data_out_a, valid_a, data_out_b, valid_b, ea_d, ea_v, eb_d, eb_v);
      end
      wr = 1'b0;
      b = 3'($urandom_range(0, 7));
      rd_addr_b = b;
      cycle();
      n_cmp++;
      if ({data_out_a, valid_a, data_out_b, valid_b} !==
          {m_data[a], m_val[a], m_data[b], m_val[b]}) begin
        n_fail++;
        $display("FAIL rand_rd_%0d: got %h/%b %h/%b, want %h/%b %h/%b",
                 n, data_out_a, valid_a, data_out_b, valid_b,
                 m_data[a], m_val[a], m_data[b], m_val[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_read();
    test_bypass();
    test_clear();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
